// File: rtl/avr_pkg.sv
// Shared constants for the AVR data-space responder: I/O register
// addresses, timer clock-select encodings and the prescaler tap decode.
package avr_pkg;

    // Absolute data addresses of the memory-mapped registers
    localparam logic [15:0] ADDR_SHADOW_TOP = 16'h001F;
    localparam logic [15:0] ADDR_PINB       = 16'h0023;
    localparam logic [15:0] ADDR_DDRB       = 16'h0024;
    localparam logic [15:0] ADDR_PORTB      = 16'h0025;
    localparam logic [15:0] ADDR_TIFR0      = 16'h0035;
    localparam logic [15:0] ADDR_TCCR0B     = 16'h0045;
    localparam logic [15:0] ADDR_TCNT0      = 16'h0046;
    localparam logic [15:0] ADDR_IO_TOP     = 16'h005F;

    // CS0 clock-select encodings; 6 and 7 also stop the timer
    localparam logic [2:0] CS_STOP    = 3'd0;
    localparam logic [2:0] CS_DIV1    = 3'd1;
    localparam logic [2:0] CS_DIV8    = 3'd2;
    localparam logic [2:0] CS_DIV64   = 3'd3;
    localparam logic [2:0] CS_DIV256  = 3'd4;
    localparam logic [2:0] CS_DIV1024 = 3'd5;

    localparam int PRESCALE_W = 10;

    // Which timer register the current bus address selects
    typedef enum logic [1:0] {
        TREG_NONE,
        TREG_TIFR,
        TREG_TCCR,
        TREG_TCNT
    } treg_e;

    // A divided tick fires when the low log2(div) prescaler bits are all ones
    function automatic logic prescale_tick(input logic [2:0] cs,
                                           input logic [PRESCALE_W-1:0] pre);
        logic t;
        t = 1'b0;
        case (cs)
            CS_DIV1:    t = 1'b1;
            CS_DIV8:    t = &pre[2:0];
            CS_DIV64:   t = &pre[5:0];
            CS_DIV256:  t = &pre[7:0];
            CS_DIV1024: t = &pre[9:0];
            default:    t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/avr_timer0.sv
// Timer/counter 0: free-running 10-bit prescaler, TCNT0, TCCR0B (CS0)
// and the TOV0 overflow flag, with a register select/write/read port.
module avr_timer0
    import avr_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  treg_e      sel,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       tov
);

    logic [PRESCALE_W-1:0] pre;
    logic [2:0]            cs;
    logic [7:0]            tcnt;
    logic                  tov_q;
    logic                  tick;
    logic                  wr_tcnt;
    logic                  wr_tccr;
    logic                  wr_tifr;

    assign tick    = prescale_tick(cs, pre);
    assign wr_tcnt = we && (sel == TREG_TCNT);
    assign wr_tccr = we && (sel == TREG_TCCR);
    assign wr_tifr = we && (sel == TREG_TIFR);
    assign tov     = tov_q;

    // Prescaler runs continuously; only reset clears it, CS0 changes do not
    always_ff @(posedge CLK) begin
        if (RST) pre <= '0;
        else     pre <= pre + 10'd1;
    end

    // Counter, clock select and overflow flag; a CPU write to TCNT0 beats a
    // coincident tick (and so suppresses its overflow), a set beats a clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            cs    <= CS_STOP;
            tcnt  <= 8'h00;
            tov_q <= 1'b0;
        end else begin
            if (wr_tccr) cs <= wdata[2:0];
            if (wr_tcnt)   tcnt <= wdata;
            else if (tick) tcnt <= tcnt + 8'd1;
            if (tick && !wr_tcnt && (tcnt == 8'hFF)) tov_q <= 1'b1;
            else if (wr_tifr && wdata[0])            tov_q <= 1'b0;
        end
    end

    // Current-value read of the selected register (registered by the caller)
    always_comb begin
        rdata = 8'h00;
        case (sel)
            TREG_TIFR: rdata = {7'b0, tov_q};
            TREG_TCCR: rdata = {5'b0, cs};
            TREG_TCNT: rdata = tcnt;
            default:   rdata = 8'h00;
        endcase
    end

endmodule

// File: rtl/avr_dmem.sv
// Data-space responder for the AVR core: address decode, internal SRAM,
// GPIO port registers, timer 0 and the one-cycle registered read path.
//
// Bus protocol: there is no valid/ready handshake. d_addr is valid every
// cycle and is always accepted (the responder is permanently ready);
// data_write is the write-valid and commits at the edge ending its cycle;
// rdata carries the contents of the previous cycle's d_addr, old value on
// a same-cycle write.
module avr_dmem
    import avr_pkg::*;
#(
    parameter logic [15:0] SRAM_BASE  = 16'h0060,
    parameter int          SRAM_DEPTH = 1024,
    parameter int          GPIO_W     = 8
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic [15:0]       d_addr,
    input  logic              data_write,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              tov_irq
);

    localparam int          AW       = $clog2(SRAM_DEPTH);
    localparam logic [16:0] SRAM_END = {1'b0, SRAM_BASE} + 17'(SRAM_DEPTH);

    logic [7:0]        mem [SRAM_DEPTH];
    logic [7:0]        sram_q;
    logic [AW-1:0]     sram_idx;
    logic              sram_hit;
    logic              sram_we;
    logic              io_region;

    logic [GPIO_W-1:0] sync1;
    logic [GPIO_W-1:0] sync2;
    logic [GPIO_W-1:0] ddr;
    logic [GPIO_W-1:0] port;

    treg_e             tsel;
    logic [7:0]        tmr_rdata;
    logic              tmr_tov;

    logic [7:0]        io_rd;
    logic [7:0]        io_q;
    logic              rd_sram;

    // SRAM window has no mirroring: only BASE..BASE+DEPTH-1 hit
    assign sram_hit  = (d_addr >= SRAM_BASE) && ({1'b0, d_addr} < SRAM_END);
    assign sram_idx  = AW'(d_addr - SRAM_BASE);
    assign sram_we   = data_write && sram_hit && !RST;
    assign io_region = (d_addr > ADDR_SHADOW_TOP) && (d_addr <= ADDR_IO_TOP);

    assign gpio_out = port;
    assign gpio_oe  = ddr;
    assign tov_irq  = tmr_tov;

    // Block-RAM style array: synchronous read sees the pre-write contents
    always_ff @(posedge CLK) begin
        if (sram_we) mem[sram_idx] <= wdata;
        sram_q <= mem[sram_idx];
    end

    // Pin synchronizer and PORTB/DDRB; writing 1s to PINB toggles PORTB
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
            ddr   <= '0;
            port  <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            if (data_write) begin
                case (d_addr)
                    ADDR_PINB:  port <= port ^ wdata[GPIO_W-1:0];
                    ADDR_DDRB:  ddr  <= wdata[GPIO_W-1:0];
                    ADDR_PORTB: port <= wdata[GPIO_W-1:0];
                    default:    ;
                endcase
            end
        end
    end

    // Map the bus address onto a timer register select
    always_comb begin
        tsel = TREG_NONE;
        case (d_addr)
            ADDR_TIFR0:  tsel = TREG_TIFR;
            ADDR_TCCR0B: tsel = TREG_TCCR;
            ADDR_TCNT0:  tsel = TREG_TCNT;
            default:     tsel = TREG_NONE;
        endcase
    end

    avr_timer0 u_timer0 (
        .CLK   (CLK),
        .RST   (RST),
        .sel   (tsel),
        .we    (data_write),
        .wdata (wdata),
        .rdata (tmr_rdata),
        .tov   (tmr_tov)
    );

    // I/O read mux; shadow, unmapped I/O and out-of-range addresses give 0
    always_comb begin
        io_rd = 8'h00;
        if (io_region) begin
            case (d_addr)
                ADDR_PINB:   io_rd = 8'(sync2);
                ADDR_DDRB:   io_rd = 8'(ddr);
                ADDR_PORTB:  io_rd = 8'(port);
                ADDR_TIFR0,
                ADDR_TCCR0B,
                ADDR_TCNT0:  io_rd = tmr_rdata;
                default:     io_rd = 8'h00;
            endcase
        end
    end

    // Read-data register: captures I/O data and which source to present
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_sram <= 1'b0;
            io_q    <= 8'h00;
        end else begin
            rd_sram <= sram_hit;
            io_q    <= io_rd;
        end
    end

    assign rdata = rd_sram ? sram_q : io_q;

endmodule

// File: tb/tb_avr_dmem.sv
// Directed plus randomized bench for avr_dmem with a behavioural model.
module tb_avr_dmem;

    localparam logic [15:0] A_PINB  = 16'h0023;
    localparam logic [15:0] A_DDRB  = 16'h0024;
    localparam logic [15:0] A_PORTB = 16'h0025;
    localparam logic [15:0] A_TIFR  = 16'h0035;
    localparam logic [15:0] A_TCCR  = 16'h0045;
    localparam logic [15:0] A_TCNT  = 16'h0046;
    localparam int          SRAM_LO = 16'h0060;
    localparam int          SRAM_HI = 16'h0060 + 1024 - 1;

    // ---------------- clock / reset / DUT ----------------
    logic        CLK;
    logic        RST;
    logic [15:0] d_addr;
    logic        data_write;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        tov_irq;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    avr_dmem #(.SRAM_BASE(16'h0060), .SRAM_DEPTH(1024), .GPIO_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .d_addr     (d_addr),
        .data_write (data_write),
        .wdata      (wdata),
        .rdata      (rdata),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .gpio_oe    (gpio_oe),
        .tov_irq    (tov_irq)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_sram [int];
    logic [7:0] m_port, m_ddr, m_pin1, m_pin2, m_tcnt;
    logic [2:0] m_cs;
    logic       m_tov;
    int         m_pre;      // clocks since reset, modulo 1024
    logic [7:0] exp_rd;
    logic       exp_known;
    logic [7:0] g_in = 8'h00;

    function automatic int div_of(input logic [2:0] cs);
        case (cs)
            3'd1: return 1;
            3'd2: return 8;
            3'd3: return 64;
            3'd4: return 256;
            3'd5: return 1024;
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock edge with the given bus inputs
    task automatic model_update(input logic rst_i, input logic [15:0] a,
                                input logic we_i, input logic [7:0] wd_i,
                                input logic [7:0] pins);
        int   d;
        logic tick;
        logic ovf;
        exp_known = 1'b1;
        exp_rd    = 8'h00;
        if (rst_i) begin
            m_port = 0; m_ddr = 0; m_pin1 = 0; m_pin2 = 0;
            m_tcnt = 0; m_cs = 0; m_tov = 0; m_pre = 0;
            return;
        end
        if (a == A_PINB)       exp_rd = m_pin2;
        else if (a == A_DDRB)  exp_rd = m_ddr;
        else if (a == A_PORTB) exp_rd = m_port;
        else if (a == A_TIFR)  exp_rd = {7'b0, m_tov};
        else if (a == A_TCCR)  exp_rd = {5'b0, m_cs};
        else if (a == A_TCNT)  exp_rd = m_tcnt;
        else if (int'(a) >= SRAM_LO && int'(a) <= SRAM_HI) begin
            if (m_sram.exists(int'(a))) exp_rd = m_sram[int'(a)];
            else exp_known = 1'b0;
        end
        d    = div_of(m_cs);
        tick = (d != 0) && ((m_pre % d) == d - 1);
        ovf  = 1'b0;
        if (we_i && a == A_TCNT) m_tcnt = wd_i;
        else if (tick) begin
            if (m_tcnt == 8'hFF) begin m_tcnt = 8'h00; ovf = 1'b1; end
            else m_tcnt = m_tcnt + 8'd1;
        end
        if (ovf) m_tov = 1'b1;
        else if (we_i && a == A_TIFR && wd_i[0]) m_tov = 1'b0;
        if (we_i) begin
            if (a == A_TCCR)  m_cs = wd_i[2:0];
            if (a == A_PINB)  m_port = m_port ^ wd_i;
            if (a == A_DDRB)  m_ddr = wd_i;
            if (a == A_PORTB) m_port = wd_i;
            if (int'(a) >= SRAM_LO && int'(a) <= SRAM_HI) m_sram[int'(a)] = wd_i;
        end
        m_pin2 = m_pin1;
        m_pin1 = pins;
        m_pre  = (m_pre + 1) % 1024;
    endtask

    // ---------------- driver: one bus cycle, then model compare ----------------
    task automatic step(input logic rst_i, input logic [15:0] a,
                        input logic we_i, input logic [7:0] wd_i);
        RST        = rst_i;
        d_addr     = a;
        data_write = we_i;
        wdata      = wd_i;
        gpio_in    = g_in;
        @(posedge CLK);
        model_update(rst_i, a, we_i, wd_i, g_in);
        #1;
        if (exp_known) chk("model_rdata", rdata, exp_rd);
        chk("model_gpio_out", gpio_out, m_port);
        chk("model_gpio_oe", gpio_oe, m_ddr);
        chk("model_tov_irq", {7'b0, tov_irq}, {7'b0, m_tov});
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 10))
            0:  return 16'($urandom_range(0, 31));
            1:  return A_PINB;
            2:  return A_DDRB;
            3:  return A_PORTB;
            4:  return A_TIFR;
            5:  return A_TCCR;
            6:  return A_TCNT;
            7:  return 16'($urandom_range(32, 95));
            8:  return 16'($urandom_range(16'h0060, 16'h006F));
            9:  return 16'($urandom_range(16'h0450, 16'h0470));
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    // ---------------- directed sequence, then random traffic ----------------
    initial begin
        RST = 1'b1; d_addr = 16'h0; data_write = 1'b0; wdata = 8'h0; gpio_in = 8'h0;
        repeat (3) step(1'b1, 16'h0000, 1'b0, 8'h00);
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_gpio_out", gpio_out, 8'h00);
        chk("reset_tov", {7'b0, tov_irq}, 8'h00);

        // SRAM at both ends of the window, and just past it
        step(1'b0, 16'h0060, 1'b1, 8'hA5);
        step(1'b0, 16'h045F, 1'b1, 8'h5A);
        step(1'b0, 16'h0060, 1'b0, 8'h00); chk("sram_first", rdata, 8'hA5);
        step(1'b0, 16'h045F, 1'b0, 8'h00); chk("sram_last", rdata, 8'h5A);
        step(1'b0, 16'h0460, 1'b0, 8'h00); chk("sram_beyond", rdata, 8'h00);

        // Back-to-back write/read and read-before-write
        step(1'b0, 16'h0100, 1'b1, 8'h11);
        step(1'b0, 16'h0100, 1'b0, 8'h00); chk("b2b_read", rdata, 8'h11);
        step(1'b0, 16'h0100, 1'b1, 8'h22); chk("rbw_old", rdata, 8'h11);
        step(1'b0, 16'h0100, 1'b0, 8'h00); chk("rbw_new", rdata, 8'h22);

        // Shadow region drops writes
        step(1'b0, 16'h0010, 1'b1, 8'hFF);
        step(1'b0, 16'h0010, 1'b0, 8'h00); chk("shadow_zero", rdata, 8'h00);

        // Timer overflow at clk/1
        step(1'b0, A_TCNT, 1'b1, 8'hFE);
        step(1'b0, A_TCCR, 1'b1, 8'h01);
        step(1'b0, 16'h0000, 1'b0, 8'h00);
        step(1'b0, A_TIFR, 1'b0, 8'h00); chk("tov_set", {7'b0, tov_irq}, 8'h01);
        step(1'b0, A_TCNT, 1'b0, 8'h00); chk("tcnt_wrapped", rdata, 8'h00);
        step(1'b0, A_TIFR, 1'b0, 8'h00); chk("tifr_read", rdata, 8'h01);
        step(1'b0, A_TIFR, 1'b1, 8'h01); chk("tov_cleared", {7'b0, tov_irq}, 8'h00);

        // Overflow set beats a coincident write-1-clear
        step(1'b0, A_TCNT, 1'b1, 8'hFE);
        step(1'b0, 16'h0000, 1'b0, 8'h00);
        step(1'b0, A_TIFR, 1'b1, 8'h01); chk("set_beats_clear", {7'b0, tov_irq}, 8'h01);

        // TCNT0 write beats a tick at 0xFF: no overflow
        step(1'b0, A_TIFR, 1'b1, 8'h01);
        step(1'b0, A_TCNT, 1'b1, 8'hFF);
        step(1'b0, A_TCNT, 1'b1, 8'h10); chk("write_no_ovf", {7'b0, tov_irq}, 8'h00);
        step(1'b0, A_TCNT, 1'b0, 8'h00); chk("tcnt_written", rdata, 8'h10);

        // clk/8: write on a tick cycle, then one advance per 8 clocks
        step(1'b0, A_TCCR, 1'b1, 8'h02);
        for (int i = 0; i < 8 && (m_pre % 8) != 7; i++) step(1'b0, 16'h0000, 1'b0, 8'h00);
        step(1'b0, A_TCNT, 1'b1, 8'h40);
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, A_TCNT, 1'b0, 8'h00);
            chk("div8_tcnt", rdata, (k <= 8) ? 8'h40 : 8'h41);
        end

        // Remaining clock selects, including the stopped encodings
        for (int cs = 3; cs <= 7; cs++) begin
            step(1'b0, A_TCCR, 1'b1, 8'(cs));
            repeat (1100) step(1'b0, A_TCNT, 1'b0, 8'h00);
        end
        step(1'b0, A_TCCR, 1'b1, 8'h00);

        // GPIO registers, PINB toggle and pin synchronizer
        step(1'b0, A_DDRB, 1'b1, 8'hF0);
        step(1'b0, A_PORTB, 1'b1, 8'h0F);
        chk("gpio_oe_f0", gpio_oe, 8'hF0);
        chk("gpio_out_0f", gpio_out, 8'h0F);
        step(1'b0, A_PINB, 1'b1, 8'h03); chk("pinb_toggle", gpio_out, 8'h0C);
        g_in = 8'h81;
        step(1'b0, A_PINB, 1'b0, 8'h00);
        step(1'b0, A_PINB, 1'b0, 8'h00);
        step(1'b0, A_PINB, 1'b0, 8'h00); chk("pinb_sync", rdata, 8'h81);
        step(1'b0, A_DDRB, 1'b0, 8'h00); chk("ddrb_read", rdata, 8'hF0);
        step(1'b0, A_PORTB, 1'b0, 8'h00); chk("portb_read", rdata, 8'h0C);

        // Reset beats coincident writes; SRAM keeps its contents
        step(1'b1, A_PORTB, 1'b1, 8'hFF);
        chk("rst_gpio_out", gpio_out, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        step(1'b1, 16'h0060, 1'b1, 8'h77);
        step(1'b0, 16'h0060, 1'b0, 8'h00); chk("sram_kept", rdata, 8'hA5);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) g_in = 8'($urandom_range(0, 255));
            step(($urandom_range(0, 199) == 0), pick_addr(),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
